// File: rtl/vend_ctrl_param_if.sv
// vend_ctrl_param_if
// Bus between the vending controller and its surroundings: the coin acceptor
// front end, the dispenser handshake and the change hopper.
//   master : the environment. It drives coin_valid, coin, cancel and vend_ready.
//   slave  : the controller. It drives vend_valid, change, change_valid,
//            coin_reject, credit and sold_count.
// Parameters CREDIT_W and COUNT_W must match the attached controller.
interface vend_ctrl_param_if #(
  parameter int CREDIT_W = 5,
  parameter int COUNT_W  = 8
);
  logic                coin_valid;
  logic [2:0]          coin;
  logic                cancel;
  logic                vend_valid;
  logic                vend_ready;
  logic [CREDIT_W-1:0] change;
  logic                change_valid;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic [COUNT_W-1:0]  sold_count;

  modport master (
    output coin_valid, coin, cancel, vend_ready,
    input  vend_valid, change, change_valid, coin_reject, credit, sold_count
  );

  modport slave (
    input  coin_valid, coin, cancel, vend_ready,
    output vend_valid, change, change_valid, coin_reject, credit, sold_count
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param
// Parametrised vending controller. It accumulates coin credit up to
// MAX_CREDIT and dispenses through a valid/ready handshake. On cancel it
// returns the held credit as change. It rejects illegal coins and coins that
// would overflow, and it counts the items sold.
// Ports:
//   clk  : system clock; all state changes on its rising edge.
//   rst  : asynchronous, active-low reset.
//   bus  : vend_ctrl_param_if.slave. It carries the coin, cancel, vend
//          handshake, change, reject, credit and sold-count signals.
// Optional feature, selected by the macro VEND_AUTO_CHANGE_EN:
//   defined   : any nonzero remainder after a vend is refunded at once.
//   undefined : the remainder is kept as credit toward the next item.
//
// state   | meaning
// COLLECT | accepting coins and cancel
// VEND    | vend_valid high, waiting for vend_ready
// REFUND  | one cycle; issues the change pulse and clears credit
module vend_ctrl_param #(
  parameter int PRICE      = 10,
  parameter int MAX_CREDIT = 20,
  parameter int CREDIT_W   = 5,
  parameter int COUNT_W    = 8
) (
  input logic              clk,
  input logic              rst,
  vend_ctrl_param_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, VEND, REFUND} state_t;

  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_q;
  logic                change_valid_q;
  logic                coin_reject_q;
  logic                vend_valid_q;
  logic [COUNT_W-1:0]  sold_q;

  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] remainder;
  logic                legal;
  logic                accept;
  logic                handshake;

  // One extra bit keeps credit+coin from wrapping before the ceiling test.
  assign sum       = {1'b0, credit_q} + {{(CREDIT_W-2){1'b0}}, bus.coin};
  assign remainder = credit_q - PRICE_C;
  assign legal     = (bus.coin == 3'd1) || (bus.coin == 3'd2) || (bus.coin == 3'd5);
  assign accept    = bus.coin_valid && (state == COLLECT) && !bus.cancel &&
                     legal && (sum <= MAX_X);
  assign handshake = vend_valid_q && bus.vend_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= COLLECT;
      credit_q       <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      vend_valid_q   <= 1'b0;
      sold_q         <= '0;
    end else begin
      coin_reject_q  <= bus.coin_valid && !accept;
      change_valid_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.cancel && (credit_q != '0)) begin
            state <= REFUND;
          end else if (accept) begin
            credit_q <= sum[CREDIT_W-1:0];
            if (sum >= PRICE_X) begin
              state        <= VEND;
              vend_valid_q <= 1'b1;
            end
          end
        end
        VEND: begin
          if (handshake) begin
            credit_q <= remainder;
            sold_q   <= sold_q + 1'b1;
`ifdef VEND_AUTO_CHANGE_EN
            vend_valid_q <= 1'b0;
            state        <= (remainder != '0) ? REFUND : COLLECT;
`else
            // A remainder that still covers the price keeps the request up.
            if (remainder < PRICE_C) begin
              vend_valid_q <= 1'b0;
              state        <= COLLECT;
            end
`endif
          end
        end
        REFUND: begin
          change_q       <= credit_q;
          change_valid_q <= 1'b1;
          credit_q       <= '0;
          state          <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.vend_valid   = vend_valid_q;
  assign bus.change       = change_q;
  assign bus.change_valid = change_valid_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.credit       = credit_q;
  assign bus.sold_count   = sold_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param
// Three controllers run on shared inputs:
//   inst0 : PRICE 10, MAX_CREDIT 20 (the default part)
//   inst1 : PRICE 10, MAX_CREDIT 12 (reaches the credit ceiling)
//   inst2 : PRICE 3,  MAX_CREDIT 20 (can hold two items' worth of credit)
// Each instance is compared against a transaction-level model every cycle.
// inst0 is also compared against a fixed vector table. Short directed
// sequences cover the ceiling, multi-item and reset corner cases.
module tb_vend_ctrl_param;

  localparam int PR[3] = '{10, 10, 3};
  localparam int MX[3] = '{20, 12, 20};
`ifdef VEND_AUTO_CHANGE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic       coin_valid_r, cancel_r, vend_ready_r;
  logic [2:0] coin_r;

  logic [4:0] o_credit[3];
  logic [4:0] o_change[3];
  logic [7:0] o_sold[3];
  logic       o_vv[3];
  logic       o_cv[3];
  logic       o_rej[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    vend_ctrl_param_if #(.CREDIT_W(5), .COUNT_W(8)) bus ();
    assign bus.coin_valid = coin_valid_r;
    assign bus.coin       = coin_r;
    assign bus.cancel     = cancel_r;
    assign bus.vend_ready = vend_ready_r;
    vend_ctrl_param #(.PRICE(PR[g]), .MAX_CREDIT(MX[g]), .CREDIT_W(5), .COUNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign o_credit[g] = bus.credit;
    assign o_change[g] = bus.change;
    assign o_sold[g]   = bus.sold_count;
    assign o_vv[g]     = bus.vend_valid;
    assign o_cv[g]     = bus.change_valid;
    assign o_rej[g]    = bus.coin_reject;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_i(input int inst, input string f, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL inst%0d %s: got %0d expected %0d at %0t", inst, f, act, exp, $time);
  endtask

  // Reference model: credit ledger, an outstanding-item flag and a pending
  // refund flag, advanced once per clock from the sampled inputs.
  int m_credit[3], m_change[3], m_sold[3];
  bit m_vv[3], m_ref[3], m_cv[3], m_rej[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_credit[i] = 0; m_change[i] = 0; m_sold[i] = 0;
      m_vv[i] = 0; m_ref[i] = 0; m_cv[i] = 0; m_rej[i] = 0;
    end
  endtask

  task automatic model_step();
    int  coin;
    bit  legal, ok;
    coin  = int'(coin_r);
    legal = (coin == 1) || (coin == 2) || (coin == 5);
    for (int i = 0; i < 3; i++) begin
      ok = coin_valid_r && !m_vv[i] && !m_ref[i] && !cancel_r && legal &&
           (m_credit[i] + coin <= MX[i]);
      m_rej[i] = coin_valid_r && !ok;
      m_cv[i]  = 1'b0;
      if (m_ref[i]) begin
        m_change[i] = m_credit[i];
        m_cv[i]     = 1'b1;
        m_credit[i] = 0;
        m_ref[i]    = 1'b0;
      end else if (m_vv[i]) begin
        if (vend_ready_r) begin
          m_credit[i] = m_credit[i] - PR[i];
          m_sold[i]   = (m_sold[i] + 1) % 256;
          if (AUTO) begin
            m_vv[i]  = 1'b0;
            m_ref[i] = (m_credit[i] != 0);
          end else begin
            m_vv[i] = (m_credit[i] >= PR[i]);
          end
        end
      end else if (cancel_r && m_credit[i] > 0) begin
        m_ref[i] = 1'b1;
      end else if (ok) begin
        m_credit[i] = m_credit[i] + coin;
        m_vv[i]     = (m_credit[i] >= PR[i]);
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk_i(i, "credit",       int'(o_credit[i]), m_credit[i]);
      chk_i(i, "vend_valid",   int'(o_vv[i]),     int'(m_vv[i]));
      chk_i(i, "coin_reject",  int'(o_rej[i]),    int'(m_rej[i]));
      chk_i(i, "change_valid", int'(o_cv[i]),     int'(m_cv[i]));
      chk_i(i, "change",       int'(o_change[i]), m_change[i]);
      chk_i(i, "sold_count",   int'(o_sold[i]),   m_sold[i]);
    end
  endtask

  task automatic drive(input bit cv, input int c, input bit can, input bit rdy);
    coin_valid_r = cv;
    coin_r       = 3'(c);
    cancel_r     = can;
    vend_ready_r = rdy;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit cv; int coin; bit cancel; bit rdy;
    int credit; bit vv; bit rej; bit chv; int chg; int sold;
  } vec_t;

  function automatic vec_t v(bit cv, int coin, bit can, bit rdy,
                             int credit, bit vv, bit rej, bit chv, int chg, int sold);
    vec_t r;
    r.cv = cv; r.coin = coin; r.cancel = can; r.rdy = rdy;
    r.credit = credit; r.vv = vv; r.rej = rej; r.chv = chv; r.chg = chg; r.sold = sold;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    // Expected outputs of inst0 after each one-cycle input vector.
    tbl.push_back(v(1,5,0,1,  5,0,0,0,0,0));
    tbl.push_back(v(1,5,0,1, 10,1,0,0,0,0));
    tbl.push_back(v(0,0,0,1,  0,0,0,0,0,1));
    tbl.push_back(v(1,5,0,1,  5,0,0,0,0,1));
    tbl.push_back(v(1,2,0,1,  7,0,0,0,0,1));
    tbl.push_back(v(1,5,0,1, 12,1,0,0,0,1));
    tbl.push_back(v(0,0,0,1,  2,0,0,0,0,2));
    if (AUTO) begin
      tbl.push_back(v(0,0,0,1, 0,0,0,1,2,2));
      tbl.push_back(v(0,0,1,1, 0,0,0,0,2,2));
      tbl.push_back(v(0,0,0,1, 0,0,0,0,2,2));
    end else begin
      tbl.push_back(v(0,0,0,1, 2,0,0,0,0,2));
      tbl.push_back(v(0,0,1,1, 2,0,0,0,0,2));
      tbl.push_back(v(0,0,0,1, 0,0,0,1,2,2));
    end
    tbl.push_back(v(1,2,0,0,  2,0,0,0,2,2));
    tbl.push_back(v(0,0,1,0,  2,0,0,0,2,2));
    tbl.push_back(v(0,0,0,0,  0,0,0,1,2,2));
    tbl.push_back(v(0,0,1,0,  0,0,0,0,2,2));
    tbl.push_back(v(0,0,0,0,  0,0,0,0,2,2));
    tbl.push_back(v(1,1,0,0,  1,0,0,0,2,2));
    tbl.push_back(v(1,5,1,0,  1,0,1,0,2,2));
    tbl.push_back(v(0,0,0,0,  0,0,0,1,1,2));
    tbl.push_back(v(1,5,0,0,  5,0,0,0,1,2));
    tbl.push_back(v(1,5,0,0, 10,1,0,0,1,2));
    tbl.push_back(v(0,0,0,0, 10,1,0,0,1,2));
    tbl.push_back(v(1,1,0,0, 10,1,1,0,1,2));
    tbl.push_back(v(0,0,0,0, 10,1,0,0,1,2));
    tbl.push_back(v(0,0,0,0, 10,1,0,0,1,2));
    tbl.push_back(v(0,0,0,0, 10,1,0,0,1,2));
    tbl.push_back(v(0,0,0,1,  0,0,0,0,1,3));

    rst = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset credit",       int'(o_credit[0]), 0);
    chk("reset vend_valid",   int'(o_vv[0]),     0);
    chk("reset change_valid", int'(o_cv[0]),     0);
    chk("reset coin_reject",  int'(o_rej[0]),    0);
    chk("reset change",       int'(o_change[0]), 0);
    chk("reset sold_count",   int'(o_sold[0]),   0);
    rst = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].cv, tbl[k].coin, tbl[k].cancel, tbl[k].rdy);
      cycle();
      total++;
      if (int'(o_credit[0]) == tbl[k].credit && o_vv[0] == tbl[k].vv &&
          o_rej[0] == tbl[k].rej && o_cv[0] == tbl[k].chv &&
          int'(o_change[0]) == tbl[k].chg && int'(o_sold[0]) == tbl[k].sold)
        passed++;
      else
        $display("FAIL vec%0d: got credit=%0d vv=%0d rej=%0d chv=%0d chg=%0d sold=%0d expected %0d %0d %0d %0d %0d %0d",
                 k, o_credit[0], o_vv[0], o_rej[0], o_cv[0], o_change[0], o_sold[0],
                 tbl[k].credit, tbl[k].vv, tbl[k].rej, tbl[k].chv, tbl[k].chg, tbl[k].sold);
    end

    // Credit ceiling on inst1 (MAX_CREDIT 12).
    apply_reset();
    drive(1, 2, 0, 0); cycle();
    drive(1, 2, 0, 0); cycle();
    drive(1, 5, 0, 0); cycle();
    chk("ceil credit9", int'(o_credit[1]), 9);
    drive(1, 5, 0, 0); cycle();
    chk("ceil reject", int'(o_rej[1]), 1);
    chk("ceil credit held", int'(o_credit[1]), 9);
    drive(1, 3, 0, 0); cycle();
    chk("illegal reject", int'(o_rej[1]), 1);
    chk("illegal credit held", int'(o_credit[1]), 9);
    drive(0, 0, 0, 0); cycle();
    chk("reject one pulse", int'(o_rej[1]), 0);

    // Two items' worth of credit on inst2 (PRICE 3).
    apply_reset();
    drive(1, 2, 0, 0); cycle();
    drive(1, 5, 0, 0); cycle();
    chk("p3 credit7", int'(o_credit[2]), 7);
    chk("p3 vend_valid", int'(o_vv[2]), 1);
    drive(0, 0, 0, 1); cycle();
    chk("p3 credit4", int'(o_credit[2]), 4);
    chk("p3 vv after 1st", int'(o_vv[2]), AUTO ? 0 : 1);
    cycle();
    chk("p3 credit end", int'(o_credit[2]), AUTO ? 0 : 1);
    chk("p3 sold", int'(o_sold[2]), AUTO ? 1 : 2);
    chk("p3 change_valid", int'(o_cv[2]), AUTO ? 1 : 0);
    chk("p3 change", int'(o_change[2]), AUTO ? 4 : 0);

    // Asynchronous reset in the middle of a pending vend on inst0.
    apply_reset();
    drive(1, 5, 0, 0); cycle();
    drive(1, 5, 0, 1); cycle();
    drive(0, 0, 0, 1); cycle();
    drive(1, 5, 0, 0); cycle();
    drive(1, 5, 0, 0); cycle();
    drive(0, 0, 0, 0); cycle();
    chk("pre-rst vend_valid", int'(o_vv[0]), 1);
    chk("pre-rst sold", int'(o_sold[0]), 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst vend_valid", int'(o_vv[0]), 0);
    chk("async rst credit", int'(o_credit[0]), 0);
    chk("async rst sold", int'(o_sold[0]), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 5, 0, 0); cycle();
    chk("post-rst credit", int'(o_credit[0]), 5);
    chk("post-rst vend_valid", int'(o_vv[0]), 0);

    // Random traffic against the model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      int c;
      c = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 7))
                                     : ((($urandom_range(0, 2)) == 0) ? 1 :
                                        (($urandom_range(0, 1) == 0) ? 2 : 5));
      drive($urandom_range(0, 9) < 4, c, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
